// File: rtl/beh_sram_dp_rw_r_pkg.sv
// Shared constants for the dual-port frame-buffer SRAM model: read latency
// bounds and the read-during-write policy encoding.
package beh_sram_dp_rw_r_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic {
    COLL_READ_OLD = 1'b0,
    COLL_READ_NEW = 1'b1
  } coll_policy_e;

  // Out-of-range latencies are pulled back to the nearest supported depth.
  function automatic int clamp_latency(input int lat);
    int res;
    if (lat < RD_LAT_MIN) begin
      res = RD_LAT_MIN;
    end else if (lat > RD_LAT_MAX) begin
      res = RD_LAT_MAX;
    end else begin
      res = lat;
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result delay line: LATENCY stages of {valid, coll, data}. The last data
// stage only loads on a valid result, so the port holds its previous read.
module sram_rd_pipe #(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             coll_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic             coll_o,
  output logic [WIDTH-1:0] data_o
);

  logic [LATENCY-1:0]            valid_q, valid_d;
  logic [LATENCY-1:0]            coll_q, coll_d;
  logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;

  logic [LATENCY:0]              valid_chain_s;
  logic [LATENCY:0]              coll_chain_s;
  logic [LATENCY:0][WIDTH-1:0]   data_chain_s;

  // Shift every stage by one; the output stage keeps its word on bubbles.
  always_comb begin
    valid_chain_s = {valid_q, valid_i};
    coll_chain_s  = {coll_q, valid_i & coll_i};
    data_chain_s  = {data_q, data_i};
    valid_d       = valid_chain_s[LATENCY-1:0];
    coll_d        = coll_chain_s[LATENCY-1:0];
    data_d        = data_chain_s[LATENCY-1:0];
    if (valid_chain_s[LATENCY-1]) begin
      data_d[LATENCY-1] = data_chain_s[LATENCY-1];
    end else begin
      data_d[LATENCY-1] = data_q[LATENCY-1];
    end
  end

  // Pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      coll_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      coll_q  <= coll_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign coll_o  = coll_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/beh_sram_dp_rw_r.sv
// Behavioural 1RW + 1R SRAM for the Ethernet MAC frame buffers: lane-masked
// writes, pipelined reads with valid tags and a port1 collision flag.
module beh_sram_dp_rw_r
  import beh_sram_dp_rw_r_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_WMASK    = 1,
  parameter int READ_LATENCY = 2,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASK-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  coll1
);

  localparam int                  LW      = DATA_WIDTH / NUM_WMASK;
  localparam int                  RL      = clamp_latency(READ_LATENCY);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam coll_policy_e        POLICY  = (WRITE_FIRST != 0) ? COLL_READ_NEW : COLL_READ_OLD;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  in0_s, in1_s;
  logic                  rd0_s, wr0_s, rd1_s, coll_s;
  logic [DATA_WIDTH-1:0] old0_s, old1_s, wr_word_s, rdata1_s;
  logic                  coll0_unused_s;

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NUM_WMASK-1:0]  mask
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NUM_WMASK; i++) begin
      if (mask[i]) begin
        res[i*LW +: LW] = new_w[i*LW +: LW];
      end else begin
        res[i*LW +: LW] = old_w[i*LW +: LW];
      end
    end
    return res;
  endfunction

  // Request decode, array lookup and the port1 bypass merge.
  always_comb begin
    in0_s = ({1'b0, addr0} < DEPTH_L);
    in1_s = ({1'b0, addr1} < DEPTH_L);
    rd0_s = !rst && !csb0 && web0;
    wr0_s = !rst && !csb0 && !web0 && in0_s;
    rd1_s = !rst && !csb1;
    if (in0_s) begin
      old0_s = mem_q[addr0];
    end else begin
      old0_s = '0;
    end
    if (in1_s) begin
      old1_s = mem_q[addr1];
    end else begin
      old1_s = '0;
    end
    wr_word_s = lane_merge(old0_s, din0, wmask0);
    coll_s    = rd1_s && wr0_s && in1_s && (addr1 == addr0);
    if (coll_s && (POLICY == COLL_READ_NEW)) begin
      rdata1_s = wr_word_s;
    end else begin
      rdata1_s = old1_s;
    end
  end

  // Array contents survive reset; out-of-range writes never reach here.
  always_ff @(posedge clk) begin
    if (wr0_s) begin
      mem_q[addr0] <= wr_word_s;
    end
  end

  sram_rd_pipe #(
    .LATENCY (RL),
    .WIDTH   (DATA_WIDTH)
  ) u_rd_pipe0 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd0_s),
    .coll_i  (1'b0),
    .data_i  (old0_s),
    .valid_o (dout0_valid),
    .coll_o  (coll0_unused_s),
    .data_o  (dout0)
  );

  sram_rd_pipe #(
    .LATENCY (RL),
    .WIDTH   (DATA_WIDTH)
  ) u_rd_pipe1 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd1_s),
    .coll_i  (coll_s),
    .data_i  (rdata1_s),
    .valid_o (dout1_valid),
    .coll_o  (coll1),
    .data_o  (dout1)
  );

endmodule

// File: tb/tb_beh_sram_dp_rw_r.sv
// Scoreboard bench: four instances (READ_LATENCY 1..4, WRITE_FIRST alternating,
// DEPTH 1000) share one stimulus stream; each has its own expectation queues.
module tb_beh_sram_dp_rw_r;

  localparam int NI = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
    logic        coll;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [9:0]  addr0, addr1;
  logic [31:0] din0;

  logic [31:0] dout0_s [NI];
  logic [31:0] dout1_s [NI];
  logic [NI-1:0] dout0_valid_s, dout1_valid_s, coll1_s;

  logic [31:0] cyc = 32'd0;
  logic        rst_d = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic [31:0] model [1024];
  exp_t        exp0_q [NI][$];
  exp_t        exp1_q [NI][$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 32'd1;
    rst_d <= rst;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [9:0] a);
    return (a < 10'd1000) ? model[a] : 32'h0;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    beh_sram_dp_rw_r #(
      .ADDR_WIDTH(10), .DEPTH(1000), .DATA_WIDTH(32), .NUM_WMASK(4),
      .READ_LATENCY(g + 1), .WRITE_FIRST(g % 2)
    ) u_dut (
      .clk(clk), .rst(rst),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(dout0_s[g]), .dout0_valid(dout0_valid_s[g]),
      .csb1(csb1), .addr1(addr1),
      .dout1(dout1_s[g]), .dout1_valid(dout1_valid_s[g]), .coll1(coll1_s[g])
    );

    logic [31:0] last0 = 32'h0;
    logic [31:0] last1 = 32'h0;
    exp_t        e0, e1;

    always @(negedge clk) begin
      if (cyc >= 32'd1) begin
        if (rst_d) begin
          chk_eq($sformatf("L%0d rst dout0", g + 1), dout0_s[g], 32'h0);
          chk_eq($sformatf("L%0d rst dout1", g + 1), dout1_s[g], 32'h0);
          chk_eq($sformatf("L%0d rst valids", g + 1),
                 {29'd0, dout0_valid_s[g], dout1_valid_s[g], coll1_s[g]}, 32'h0);
          last0 = 32'h0;
          last1 = 32'h0;
        end else begin
          if (dout0_valid_s[g] === 1'b1) begin
            if (exp0_q[g].size() == 0) begin
              chk_eq($sformatf("L%0d rd0 unexpected valid", g + 1), 32'd1, 32'd0);
            end else begin
              e0 = exp0_q[g].pop_front();
              chk_eq($sformatf("L%0d rd0 cycle", g + 1), cyc, e0.cyc);
              chk_eq($sformatf("L%0d rd0 data", g + 1), dout0_s[g], e0.data);
              last0 = e0.data;
            end
          end else begin
            chk_eq($sformatf("L%0d rd0 hold", g + 1), dout0_s[g], last0);
          end
          if (dout1_valid_s[g] === 1'b1) begin
            if (exp1_q[g].size() == 0) begin
              chk_eq($sformatf("L%0d rd1 unexpected valid", g + 1), 32'd1, 32'd0);
            end else begin
              e1 = exp1_q[g].pop_front();
              chk_eq($sformatf("L%0d rd1 cycle", g + 1), cyc, e1.cyc);
              chk_eq($sformatf("L%0d rd1 data", g + 1), dout1_s[g], e1.data);
              chk_eq($sformatf("L%0d coll1", g + 1), {31'd0, coll1_s[g]}, {31'd0, e1.coll});
              last1 = e1.data;
            end
          end else begin
            chk_eq($sformatf("L%0d rd1 hold", g + 1), dout1_s[g], last1);
            chk_eq($sformatf("L%0d coll1 idle", g + 1), {31'd0, coll1_s[g]}, 32'h0);
          end
        end
      end
    end
  end

  // One request cycle, driven at a falling edge; expectations are queued now.
  task automatic op(input logic c0, input logic w0, input logic [3:0] m, input logic [9:0] a0,
                    input logic [31:0] d0, input logic c1, input logic [9:0] a1);
    exp_t        e;
    logic [31:0] old1;
    logic        coll;
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
    if (!rst) begin
      if (!c0 && w0) begin
        for (int g = 0; g < NI; g++) begin
          e.cyc = cyc + 32'(g + 1); e.data = mread(a0); e.coll = 1'b0;
          exp0_q[g].push_back(e);
        end
      end
      if (!c1) begin
        old1 = mread(a1);
        coll = !c0 && !w0 && (a0 == a1) && (a1 < 10'd1000);
        for (int g = 0; g < NI; g++) begin
          e.cyc  = cyc + 32'(g + 1);
          e.data = (coll && (g % 2 == 1)) ? merge(old1, d0, m) : old1;
          e.coll = coll;
          exp1_q[g].push_back(e);
        end
      end
      if (!c0 && !w0 && (a0 < 10'd1000)) model[a0] = merge(model[a0], d0, m);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b1, 1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 10'd0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    op(1'b0, 1'b0, m, a, d, 1'b1, 10'd0);
  endtask

  task automatic rd0(input logic [9:0] a);
    op(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b1, 10'd0);
  endtask

  task automatic rd1(input logic [9:0] a);
    op(1'b1, 1'b1, 4'h0, 10'd0, 32'h0, 1'b0, a);
  endtask

  // One reset cycle; results that would land on or after the reset edge are dropped.
  task automatic pulse_rst();
    rst = 1'b1; csb0 = 1'b1; csb1 = 1'b1;
    for (int g = 0; g < NI; g++) begin
      while (exp0_q[g].size() > 0 && exp0_q[g][$].cyc >= cyc + 32'd1) void'(exp0_q[g].pop_back());
      while (exp1_q[g].size() > 0 && exp1_q[g][$].cyc >= cyc + 32'd1) void'(exp1_q[g].pop_back());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] ra0, ra1;
    rst = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 10'd0; din0 = 32'h0;
    csb1 = 1'b1; addr1 = 10'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wr(10'd5, 32'hDEADBEEF, 4'hF);
    rd1(10'd5);
    idle(5);
    wr(10'd5, 32'h11223344, 4'b0101);
    rd0(10'd5);
    idle(5);
    wr(10'd5, 32'hFFFFFFFF, 4'h0);
    rd1(10'd5);

    wr(10'd7, 32'hAAAAAAAA, 4'hF);
    op(1'b0, 1'b0, 4'hF, 10'd7, 32'h55555555, 1'b0, 10'd7);
    wr(10'd8, 32'h01234567, 4'hF);
    op(1'b0, 1'b0, 4'b1001, 10'd8, 32'hFFFFFFFF, 1'b0, 10'd8);
    rd1(10'd8);
    idle(5);

    foreach (model[i]) if (i < 7 && i != 5) wr(10'(i), 32'hC0DE0000 + 32'(i), 4'hF);
    for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 4'h0, 10'(7 - i), 32'h0, 1'b0, 10'(i));
    idle(6);

    rd0(10'd5);
    pulse_rst();
    idle(5);
    rd0(10'd5);
    idle(5);

    wr(10'd10, 32'h10101010, 4'hF);
    wr(10'd1010, 32'hCAFEF00D, 4'hF);
    rd0(10'd1010);
    op(1'b0, 1'b0, 4'hF, 10'd1010, 32'h12345678, 1'b0, 10'd1010);
    rd1(10'd10);
    rd0(10'd1023);
    idle(5);

    for (int i = 32; i < 48; i++) wr(10'(i), $urandom, 4'hF);
    for (int n = 0; n < 300; n++) begin
      ra0 = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(32, 47));
      ra1 = ($urandom_range(0, 2) == 0) ? ra0 : 10'($urandom_range(32, 47));
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra0,
         $urandom, 1'($urandom_range(0, 1)), ra1);
    end
    idle(8);

    for (int g = 0; g < NI; g++) begin
      chk_eq($sformatf("L%0d rd0 outstanding", g + 1), 32'(exp0_q[g].size()), 32'd0);
      chk_eq($sformatf("L%0d rd1 outstanding", g + 1), 32'(exp1_q[g].size()), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
